// File: rtl/fc_tile_sequencer_if.sv
// fc_tile_sequencer_if
//   Bundles the handshake and address signals between the FC tile sequencer
//   and its surroundings: the layer controller, the activation buffer, the
//   weight ROM, the MAC datapath and the output buffer.
//   master : the sequencer side. It receives start/src_ready and drives
//            busy, mac_*, act/wgt addresses, out_we/out_addr and done.
//   slave  : the environment side, with the opposite directions.
//   IW = activation index width, GW = group index width,
//   WW = weight row index width.
interface fc_tile_sequencer_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned GW = 8,
    parameter int unsigned WW = 20
);
    logic          start;
    logic          src_ready;
    logic          busy;
    logic          mac_valid;
    logic          mac_first;
    logic          mac_last;
    logic [IW-1:0] act_addr;
    logic [WW-1:0] wgt_addr;
    logic          out_we;
    logic [GW-1:0] out_addr;
    logic          done;

    modport master (
        input  start, src_ready,
        output busy, mac_valid, mac_first, mac_last,
        output act_addr, wgt_addr, out_we, out_addr, done
    );

    modport slave (
        output start, src_ready,
        input  busy, mac_valid, mac_first, mac_last,
        input  act_addr, wgt_addr, out_we, out_addr, done
    );
endinterface

// File: rtl/fc_tile_sequencer.sv
// fc_tile_sequencer
//   Sequences one fully-connected layer on the lane-parallel MAC datapath.
//   Output neurons are handled in groups of LANES. For each group the block
//   streams IN_LEN input beats, with activation and weight addresses and
//   first/last markers. It then follows the fixed datapath latency and issues
//   the write of the group result.
// Ports
//   clk_i  : clock; all state changes on the rising edge
//   rst_ni : asynchronous, active-low reset
//   bus    : fc_tile_sequencer_if.master
//            start/src_ready in
//            busy, mac_valid/first/last, act_addr, wgt_addr,
//            out_we, out_addr, done out
module fc_tile_sequencer #(
    parameter int unsigned IN_LEN   = 4096,
    parameter int unsigned OUT_LEN  = 4096,
    parameter int unsigned LANES    = 16,
    parameter int unsigned PIPE_LAT = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fc_tile_sequencer_if.master bus
);
    localparam int unsigned NGRP = OUT_LEN / LANES;
    localparam int unsigned IW   = $clog2(IN_LEN);
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned WW   = $clog2(IN_LEN * NGRP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q,   state_d;
    logic [IW-1:0]       in_cnt_q,  in_cnt_d;
    logic [GW-1:0]       grp_q,     grp_d;
    logic [WW-1:0]       wgt_q,     wgt_d;
    logic [GW-1:0]       res_grp_q, res_grp_d;
    logic [PIPE_LAT-1:0] lat_q,     lat_d;

    logic mac_valid;
    logic mac_last;
    logic last_grp;

    assign mac_valid = (state_q == S_RUN) && bus.src_ready;
    assign mac_last  = mac_valid && (in_cnt_q == IW'(IN_LEN - 1));
    assign last_grp  = (grp_q == GW'(NGRP - 1));

    // Delay line for mac_last. Its tail is the output-buffer write strobe.
    // Reset clears it, so a write already in flight is dropped.
    assign lat_d = (lat_q << 1) | PIPE_LAT'(mac_last);

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        grp_d     = grp_q;
        wgt_d     = wgt_q;
        res_grp_d = res_grp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    in_cnt_d = '0;
                    grp_d    = '0;
                    wgt_d    = '0;
                end
            end
            S_RUN: begin
                if (mac_valid) begin
                    // IN_LEN is a power of two, so in_cnt wraps by itself.
                    in_cnt_d = in_cnt_q + IW'(1);
                    wgt_d    = wgt_q + WW'(1);
                end
                if (mac_last) begin
                    // One result register is enough. The next mac_last is
                    // at least IN_LEN >= PIPE_LAT cycles away, so the
                    // pending write always happens before it.
                    res_grp_d = grp_q;
                    grp_d     = last_grp ? '0 : grp_q + GW'(1);
                    if (last_grp) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Earlier groups have finished their writes before this
                // state, so the strobe seen here is the final one.
                if (lat_q[PIPE_LAT-1]) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            grp_q     <= '0;
            wgt_q     <= '0;
            res_grp_q <= '0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            grp_q     <= grp_d;
            wgt_q     <= wgt_d;
            res_grp_q <= res_grp_d;
            lat_q     <= lat_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mac_valid = mac_valid;
    assign bus.mac_first = mac_valid && (in_cnt_q == '0);
    assign bus.mac_last  = mac_last;
    assign bus.act_addr  = in_cnt_q;
    assign bus.wgt_addr  = wgt_q;
    assign bus.out_we    = lat_q[PIPE_LAT-1];
    assign bus.out_addr  = res_grp_q;
    assign bus.done      = (state_q == S_DONE);
endmodule
